// File: rtl/sccb_master.sv
// SCCB/I2C register-write master: START, dev/reg-hi/reg-lo/data bytes with ACK checks, STOP.
// Define SCCB_READ_EN to build the register-read sequence (STOP, re-START, read byte, master NACK).
module sccb_master #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int SCL_FREQ_HZ = 100000,
  parameter int QDIV        = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ)
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [15:0] cmd_reg_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        cmd_rd,
  output logic        done,
  output logic        ack_err,
  output logic [7:0]  rdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);
  localparam int CW = $clog2(QDIV);

  typedef enum logic [3:0] {
    IDLE, START, DEV, ACK, RAH, RAL, DATA, STOP
`ifdef SCCB_READ_EN
    , RDATA, MNACK
`endif
  } state_t;

  state_t          state_q, state_d, byte_q, byte_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      q_q, q_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      dev_q, dev_d;
  logic [15:0]     reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            smp_q, smp_d, nack_q, nack_d, err_q, err_d;
  logic            done_q, done_d, ready_q, ready_d, scl_q, scl_d, sda_q, sda_d;
  logic            qend, bend, rw;
  logic [7:0]      txb;
`ifdef SCCB_READ_EN
  logic            rd_q, rd_d, ph2_q, ph2_d;
  logic [7:0]      rdata_q, rdata_d;
`else
  logic            unused_cmd_rd;
  assign unused_cmd_rd = cmd_rd;
`endif

  always_comb begin
    qend    = (cnt_q == CW'(QDIV - 1));
    bend    = qend && (q_q == 2'd3);
    state_d = state_q;
    byte_d  = byte_q;
    cnt_d   = qend ? '0 : cnt_q + CW'(1);
    q_d     = qend ? q_q + 2'd1 : q_q;
    bit_d   = bit_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    smp_d   = (qend && q_q == 2'd2) ? sda_i : smp_q;
    nack_d  = nack_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef SCCB_READ_EN
    rd_d    = rd_q;
    ph2_d   = ph2_q;
    rdata_d = rdata_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        q_d     = 2'd0;
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          dev_d   = cmd_dev_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          ready_d = 1'b0;
          err_d   = 1'b0;
          nack_d  = 1'b0;
          state_d = START;
`ifdef SCCB_READ_EN
          rd_d    = cmd_rd;
          ph2_d   = 1'b0;
`endif
        end
      end
      START: if (bend) begin
        state_d = DEV;
        bit_d   = 3'd0;
      end
      DEV, RAH, RAL, DATA: if (bend) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = ACK;
          byte_d  = state_q;
        end
      end
      ACK: if (bend) begin
        if (smp_q) begin
          nack_d  = 1'b1;
          state_d = STOP;
        end else begin
          case (byte_q)
`ifdef SCCB_READ_EN
            DEV:     state_d = ph2_q ? RDATA : RAH;
            RAL:     state_d = (rd_q && !ph2_q) ? STOP : DATA;
`else
            DEV:     state_d = RAH;
            RAL:     state_d = DATA;
`endif
            RAH:     state_d = RAL;
            default: state_d = STOP;
          endcase
        end
      end
      STOP: if (bend) begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = nack_q;
`ifdef SCCB_READ_EN
        // First half of a read ends here; restart for the read-direction address.
        if (rd_q && !ph2_q && !nack_q) begin
          state_d = START;
          done_d  = 1'b0;
          ph2_d   = 1'b1;
        end
`endif
      end
`ifdef SCCB_READ_EN
      RDATA: begin
        if (qend && q_q == 2'd2) rdata_d = {rdata_q[6:0], sda_i};
        if (bend) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = MNACK;
        end
      end
      MNACK: if (bend) state_d = STOP;
`endif
      default: state_d = IDLE;
    endcase

`ifdef SCCB_READ_EN
    rw = ph2_d;
`else
    rw = 1'b0;
`endif
    case (state_d)
      DEV:     txb = {dev_d, rw};
      RAH:     txb = reg_d[15:8];
      RAL:     txb = reg_d[7:0];
      default: txb = wdata_d;
    endcase
    // Line levels are decoded from the next state so the pins change with the state register.
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_d)
      IDLE: ;
      START: begin
        scl_d = (q_d == 2'd3);
        sda_d = q_d[1];
      end
      DEV, RAH, RAL, DATA: begin
        scl_d = ~q_d[1];
        sda_d = ~txb[3'd7 - bit_d];
      end
      STOP: begin
        scl_d = (q_d == 2'd0);
        sda_d = ~q_d[1];
      end
      default: scl_d = ~q_d[1];
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= IDLE;
      cnt_q   <= '0;
      q_q     <= 2'd0;
      bit_q   <= 3'd0;
      dev_q   <= 7'd0;
      reg_q   <= 16'd0;
      wdata_q <= 8'd0;
      smp_q   <= 1'b0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
`ifdef SCCB_READ_EN
      rd_q    <= 1'b0;
      ph2_q   <= 1'b0;
      rdata_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      smp_q   <= smp_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
`ifdef SCCB_READ_EN
      rd_q    <= rd_d;
      ph2_q   <= ph2_d;
      rdata_q <= rdata_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign ack_err   = err_q;
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
`ifdef SCCB_READ_EN
  assign rdata     = rdata_q;
`else
  assign rdata     = 8'h00;
`endif

endmodule

// File: doc/sccb_master.md
Name: sccb_master

Overview:
- Command-driven SCCB/I2C write master that configures the camera sensor feeding the MIPI CSI-2 receive path over the mipi_scl/mipi_sda lines.
- Takes one register-write command at a time: 7-bit device address, 16-bit register address, 8-bit data.
- Serialises the command onto open-drain SCL/SDA, checks each ACK slot and reports completion or error.
- Sits in the top level between the sensor-init sequencer/VIO and the camera connector pins.

Parameters:
- CLK_FREQ_HZ, 50000000, frequency of clk_50m.
- SCL_FREQ_HZ, 100000, SCL bit rate.
- QDIV, CLK_FREQ_HZ/(4*SCL_FREQ_HZ) = 125, clk_50m cycles per quarter bit; must be ≥ 4.

Ports:
- clk_50m  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block idle; command accepted on cmd_valid & cmd_ready.
- cmd_dev_addr  input  7  7-bit device address.
- cmd_reg_addr  input  16  register address, sent MSB byte first.
- cmd_wdata  input  8  write data.
- cmd_rd  input  1  read request; ignored unless SCCB_READ_EN.
- done  output  1  one-cycle pulse at end of transaction.
- ack_err  output  1  valid with done: 1 = a NACK was received.
- rdata  output  8  read data, valid with done (SCCB_READ_EN only; 0 otherwise).
- scl_oe  output  1  1 = drive SCL low, 0 = release.
- sda_oe  output  1  1 = drive SDA low, 0 = release.
- sda_i  input  1  sampled SDA pin level, already synchronised by top.

Behaviour:
- Clock and reset: one clock, clk_50m. rst_n is asynchronous and active-low.
- Reset values: scl_oe=0, sda_oe=0 (bus released), cmd_ready=1, done=0, ack_err=0, rdata=0, FSM=IDLE, quarter counter=0.
- Command capture: fields are latched on the acceptance cycle. cmd_ready drops the next cycle and stays 0 until the cycle after done.
- Timing base: the quarter counter counts 0..QDIV-1 and steps the quarter index q 0..3. One bit = 4*QDIV = 500 cycles.
- Data bits:
  - q0, q1: SCL low (scl_oe=1); SDA updated at the start of q0.
  - q2, q3: SCL high (scl_oe=0).
  - SDA sampled on the last cycle of q2.
- FSM states: IDLE, START, DEV, ACK, RAH, RAL, DATA, STOP.
- IDLE: both lines released. On accept → START.
- START: 4 quarters.
  - q0, q1: SDA and SCL high.
  - q2: SDA low with SCL high.
  - q3: SCL low.
- Byte states DEV/RAH/RAL/DATA: 8 bits, MSB first.
  - DEV byte = {cmd_dev_addr, 1'b0}.
  - sda_oe = ~bit.
- ACK: one bit with SDA released. Sampled 0 = ACK → next byte state or STOP. Sampled 1 = NACK → set error flag, go directly to STOP (remaining bytes skipped).
- STOP: 4 quarters.
  - q0, q1: SDA low, SCL low then high.
  - q2: SDA released with SCL high.
  - q3: idle.
  - On the last cycle: pulse done, drive ack_err, return to IDLE.
- Write latency: accept to done = 500 + 36*500 + 500 = 19000 cycles.
- Error flag: ack_err holds its value until the next accept, where it is cleared.
- Simultaneous events: cmd_valid while busy is ignored; the command is not queued.
- Reset mid-transaction: lines release asynchronously. No STOP is generated. The sensor recovers on the next START.
- Clock stretching is not supported; scl is not sampled.

Optional Feature:
- Macro: SCCB_READ_EN.
- With the macro, cmd_rd=1 runs a read:
  - START, DEV(W), ACK, RAH, ACK, RAL, ACK, then STOP.
  - Then START, DEV byte {addr,1}, ACK, RDATA.
  - RDATA: 8 bits with SDA released, sampled MSB first.
  - Then master NACK (SDA released one bit), then STOP.
  - rdata is updated before done.
- Without the macro: cmd_rd is ignored, every command is a write, rdata is tied to 0, and the read states are not built.

Test Plan:
- Reset then idle: after rst_n release → cmd_ready=1, scl_oe=sda_oe=0, no done for 10000 cycles.
- Write: dev 0x3C, reg 0x3008, data 0x82, slave model ACKs → bytes 0x78, 0x30, 0x08, 0x82 observed on SDA. done at accept+19000 cycles, ack_err=0.
- Device NACK: dev 0x21, slave never ACKs → STOP directly after the 9th bit, done at accept+5500 cycles, ack_err=1. The next good write clears ack_err.
- Busy rejection: second cmd_valid pulse 1000 cycles after accept → not accepted, only one done, bus sequence unchanged.
- Reset mid-byte: rst_n low during RAH → scl_oe=sda_oe=0 within the same cycle, cmd_ready=1 after release. The following write completes normally.
- SCCB_READ_EN read: reg 0x300A, slave returns 0x56 → rdata=0x56 with done, ack_err=0, master NACK seen on the 9th read bit.
